// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the arbiter and uart_tx.
// Names are from the arbiter's point of view: i_ = into the arbiter, o_ = out of it.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]   i_req_last;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [NUM_REQ-1:0]   o_grant;
    logic [7:0]           o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_busy;
    logic                 o_timeout_err;

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_busy,
        output o_req_ready, o_grant, o_tx_data, o_tx_valid, o_timeout_err
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_busy,
        input  o_req_ready, o_grant, o_tx_data, o_tx_valid, o_timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one uart_tx among NUM_REQ requesters.
// Optional UART_ARB_TAG_EN: an ASCII '0'+index tag byte precedes each granted packet.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; arbitrate among req_valid from r_ptr upward
// S_TAG   | owner granted, send its tag byte (UART_ARB_TAG_EN only)
// S_ISSUE | wait for tx_busy low and owner's byte, then issue it
// S_WBUSY | wait for tx_busy to rise, bounded by BUSY_TIMEOUT
// S_WIDLE | wait for tx_busy to fall; release on last byte
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_ISSUE,
        S_WBUSY,
        S_WIDLE
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,  w_grant_nxt;
    logic [IW-1:0]      r_idx,    w_idx_nxt;
    logic [IW-1:0]      r_ptr,    w_ptr_nxt;
    logic               r_last,   w_last_nxt;
    logic [7:0]         r_cnt,    w_cnt_nxt;
    logic               r_err,    w_err_nxt;

    logic               w_any;
    logic [IW-1:0]      w_win_idx;
    logic               w_tx_valid;
    logic [7:0]         w_tx_data;
    logic [NUM_REQ-1:0] w_req_ready;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Walk downward so the lowest offset from r_ptr is the last assignment and wins.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.i_req_valid[wrap_idx(r_ptr, k)]) begin
                w_any     = 1'b1;
                w_win_idx = wrap_idx(r_ptr, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_tx_valid  = 1'b0;
        w_tx_data   = 8'h00;
        w_req_ready = '0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                    w_idx_nxt   = w_win_idx;
                    w_ptr_nxt   = (w_win_idx == IW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
`ifdef UART_ARB_TAG_EN
                    w_state_nxt = S_TAG;
`else
                    w_state_nxt = S_ISSUE;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                if (!bus.i_tx_busy) begin
                    w_tx_valid  = 1'b1;
                    w_tx_data   = 8'h30 + 8'(r_idx);
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = 8'(BUSY_TIMEOUT);
                    w_state_nxt = S_WBUSY;
                end
            end
`endif
            S_ISSUE: begin
                if (!bus.i_tx_busy && bus.i_req_valid[r_idx]) begin
                    w_tx_valid  = 1'b1;
                    w_tx_data   = bus.i_req_data[{r_idx, 3'b000} +: 8];
                    w_req_ready = r_grant;
                    w_last_nxt  = bus.i_req_last[r_idx];
                    w_cnt_nxt   = 8'(BUSY_TIMEOUT);
                    w_state_nxt = S_WBUSY;
                end
            end
            S_WBUSY: begin
                if (bus.i_tx_busy) begin
                    w_state_nxt = S_WIDLE;
                end else if (r_cnt <= 8'd1) begin
                    // uart_tx never acknowledged: flag it and move on as if sent
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WIDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_WIDLE: begin
                if (!bus.i_tx_busy) begin
                    if (r_last) begin
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.o_grant       = r_grant;
    assign bus.o_tx_valid    = w_tx_valid;
    assign bus.o_tx_data     = w_tx_data;
    assign bus.o_req_ready   = w_req_ready;
    assign bus.o_timeout_err = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model and
// queue-driven requesters; expectations follow UART_ARB_TAG_EN if defined.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
`ifdef UART_ARB_TAG_EN
    localparam int TAGN = 1;
`else
    localparam int TAGN = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // requester sources: bit 8 = last flag
    logic [8:0]         src_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] hold = '0;
    int                 popped [NUM_REQ];
    int                 fire_seen = 0;
    int                 busy_cnt  = 0;
    logic               m_dead    = 1'b0;

    // written by the monitor only
    logic [7:0]         log_data  [$];
    logic [NUM_REQ-1:0] log_rdy   [$];
    logic [NUM_REQ-1:0] log_grant [$];
    int                 rdy_cnt [NUM_REQ];
    int                 fire_cnt   = 0;
    int                 viol_busy  = 0;
    int                 viol_pulse = 0;
    logic               prev_v     = 1'b0;

    logic [7:0]         exp_data [$];
    logic [NUM_REQ-1:0] exp_rdy  [$];
    int                 base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.o_tx_valid) begin
                if (bus.i_tx_busy) viol_busy++;
                if (prev_v) viol_pulse++;
                log_data.push_back(bus.o_tx_data);
                log_rdy.push_back(bus.o_req_ready);
                log_grant.push_back(bus.o_grant);
                fire_cnt++;
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.o_req_ready[i]) rdy_cnt[i]++;
            prev_v = bus.o_tx_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic tick();
        logic [NUM_REQ-1:0]   v;
        logic [NUM_REQ-1:0]   l;
        logic [8*NUM_REQ-1:0] d;
        @(posedge clk);
        #1;
        if (fire_cnt != fire_seen) begin
            fire_seen = fire_cnt;
            busy_cnt  = m_dead ? 0 : 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        bus.i_tx_busy = (busy_cnt != 0);
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            while (popped[i] != rdy_cnt[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                popped[i]++;
            end
            if (src_q[i].size() > 0 && !hold[i]) begin
                v[i]         = 1'b1;
                d[8*i +: 8]  = src_q[i][0][7:0];
                l[i]         = src_q[i][0][8];
            end
        end
        bus.i_req_valid = v;
        bus.i_req_data  = d;
        bus.i_req_last  = l;
    endtask

    task automatic src_pkt(input int idx, input string s);
        for (int k = 0; k < s.len(); k++)
            src_q[idx].push_back({(k == s.len() - 1), s[k]});
    endtask

    task automatic exp_pkt(input int idx, input string s);
        if (TAGN != 0) begin
            exp_data.push_back(8'(8'h30 + idx));
            exp_rdy.push_back('0);
        end
        for (int k = 0; k < s.len(); k++) begin
            exp_data.push_back(s[k]);
            exp_rdy.push_back(NUM_REQ'(1) << idx);
        end
    endtask

    task automatic wait_log(input int n, input string tag);
        int b = 0;
        while (log_data.size() < n && b < 600) begin
            tick();
            b++;
        end
        chk(tag, 32'(log_data.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int b = 0;
        while (bus.o_grant != '0 && b < 600) begin
            tick();
            b++;
        end
        chk(tag, 32'(bus.o_grant), 32'd0);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, 32'(log_data.size() - base), 32'(exp_data.size()));
        for (int k = 0; k < exp_data.size(); k++) begin
            if (base + k < log_data.size()) begin
                chk($sformatf("%s_d%0d", tag, k), 32'(log_data[base + k]), 32'(exp_data[k]));
                chk($sformatf("%s_r%0d", tag, k), 32'(log_rdy[base + k]),  32'(exp_rdy[k]));
            end
        end
    endtask

    task automatic start_test();
        base = log_data.size();
        exp_data.delete();
        exp_rdy.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_req_last  = '0;
        bus.i_tx_busy   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) popped[i] = 0;

        // 1: reset values, then a single-byte packet from req0
        do_reset();
        @(negedge clk);
        chk("rst_grant",    32'(bus.o_grant),       32'd0);
        chk("rst_tx_valid", 32'(bus.o_tx_valid),    32'd0);
        chk("rst_tx_data",  32'(bus.o_tx_data),     32'd0);
        chk("rst_ready",    32'(bus.o_req_ready),   32'd0);
        chk("rst_err",      32'(bus.o_timeout_err), 32'd0);
        start_test();
        src_pkt(0, "a");
        exp_pkt(0, "a");
        wait_log(base + exp_data.size(), "t1_fire");
        chk("t1_grant_at_fire", 32'(log_grant[log_grant.size() - 1]), 32'b0001);
        wait_idle("t1_release");
        chk("t1_busy_low_at_release", 32'(bus.i_tx_busy), 32'd0);
        chk_log("t1");

        // 2: all four valid with single-byte packets, req0 has a second one
        do_reset();
        start_test();
        src_pkt(0, "A"); src_pkt(1, "B"); src_pkt(2, "C"); src_pkt(3, "D"); src_pkt(0, "E");
        exp_pkt(0, "A"); exp_pkt(1, "B"); exp_pkt(2, "C"); exp_pkt(3, "D"); exp_pkt(0, "E");
        wait_log(base + exp_data.size(), "t2_fire");
        wait_idle("t2_release");
        chk_log("t2");

        // 3: multi-byte packet from req1 held against req2, with a mid-packet stall
        do_reset();
        start_test();
        src_pkt(1, "hi\n");
        src_pkt(2, "X");
        exp_pkt(1, "hi\n");
        exp_pkt(2, "X");
        wait_log(base + TAGN + 1, "t3_first");
        hold[1] = 1'b1;
        repeat (20) tick();
        chk("t3_stall_count", 32'(log_data.size() - base), 32'(TAGN + 1));
        chk("t3_stall_grant", 32'(bus.o_grant), 32'b0010);
        hold[1] = 1'b0;
        wait_log(base + exp_data.size(), "t3_fire");
        wait_idle("t3_release");
        chk_log("t3");

        // 4: uart never goes busy -> sticky timeout, arbiter still completes
        do_reset();
        m_dead = 1'b1;
        start_test();
        src_pkt(0, "T");
        exp_pkt(0, "T");
        wait_log(base + 1, "t4_first");
        repeat (60) tick();
        chk("t4_err_early", 32'(bus.o_timeout_err), 32'd0);
        repeat (10) tick();
        chk("t4_err_set", 32'(bus.o_timeout_err), 32'd1);
        wait_idle("t4_release");
        chk_log("t4");
        chk("t4_err_sticky", 32'(bus.o_timeout_err), 32'd1);
        m_dead = 1'b0;
        do_reset();
        chk("t4_err_cleared", 32'(bus.o_timeout_err), 32'd0);

        // 5: reset while waiting for busy; pending byte survives, ptr back to 0
        do_reset();
        start_test();
        src_pkt(0, "PQ");
        wait_log(base + TAGN + 1, "t5_first");
        reset = 1'b1;
        tick();
        chk("t5_grant_after_rst", 32'(bus.o_grant), 32'd0);
        @(negedge clk);
        chk("t5_valid_after_rst", 32'(bus.o_tx_valid),  32'd0);
        chk("t5_ready_after_rst", 32'(bus.o_req_ready), 32'd0);
        reset = 1'b0;
        start_test();
        src_pkt(1, "R");
        exp_pkt(0, "Q");
        exp_pkt(1, "R");
        wait_log(base + exp_data.size(), "t5_fire");
        wait_idle("t5_release");
        chk_log("t5");

        // 6: req3 single byte (tag byte '3' leads it when tagging is built in)
        do_reset();
        start_test();
        src_pkt(3, "z");
        exp_pkt(3, "z");
        wait_log(base + exp_data.size(), "t6_fire");
        wait_idle("t6_release");
        chk_log("t6");

        chk("valid_while_busy", 32'(viol_busy),  32'd0);
        chk("valid_pulse_len",  32'(viol_pulse), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
